// File: rtl/vga_frame_reader_pkg.sv
// Shared constants and op codes for the VGA frame reader and its ZBT op pipeline.
//   ZBT_ADDR_W  ZBT word address width; the MSB selects the frame bank.
//   ZBT_DATA_W  ZBT word width: two 18-bit pixels.
//   ZBT_LAT     ZBT pipeline latency from address to data, in cycles.
//   LINE_WORDS  Words per display line (640 px / 2).
//   op_e        Kind of memory slot issued in a cycle.
package vga_frame_reader_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int ZBT_LAT    = 2;
    localparam int LINE_WORDS = 320;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_e;

endpackage

// File: rtl/zbt_op_pipe.sv
// Delay line that tracks each issued memory slot until its data phase on the ZBT.
//   clock     in   System clock, posedge.
//   reset     in   Synchronous, active-high; flushes every stage to OP_IDLE.
//   op_in     in   Slot kind issued this cycle.
//   data_in   in   Write data captured alongside a WRITE slot.
//   op_out    out  Slot kind issued DEPTH cycles ago.
//   data_out  out  Data travelling with op_out.
module zbt_op_pipe
    import vga_frame_reader_pkg::*;
#(
    parameter int DEPTH  = ZBT_LAT,
    parameter int DATA_W = ZBT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  op_e               op_in,
    input  logic [DATA_W-1:0] data_in,
    output op_e               op_out,
    output logic [DATA_W-1:0] data_out
);

    op_e               op_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its neighbour held before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) op_q[i] <= OP_IDLE;
        end else begin
            op_q[0] <= op_in;
            for (int i = 1; i < DEPTH; i++) op_q[i] <= op_q[i-1];
        end
    end

    // NOTE: the data lane is deliberately not reset; it is only ever consumed
    // when the matching op stage says WRITE, and the op lane is flushed.
    always_ff @(posedge clock) begin
        data_q[0] <= data_in;
        for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end

    assign op_out   = op_q[DEPTH-1];
    assign data_out = data_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// Arbitrates VGA word reads and pipeline frame writes onto a double-buffered ZBT.
// Reads have strict priority; writes go to the back bank; the display bank swaps
// only on a read of word (0,0) after a frame_flag.
//   clock, reset                 System clock; synchronous active-high reset.
//   frame_flag                   Pulse: back bank complete, request a swap.
//   vga_flag, hcount, vcount     Read request for the word holding (hcount, vcount).
//   done_vga                     Pulse: read address issued.
//   vga_pixel, vga_pixel_vld     Read data and its one-cycle valid.
//   wr_req, wr_addr, wr_data     Held write request into the back bank.
//   wr_ack                       Pulse: write address issued.
//   mem_addr, mem_we_b           ZBT address and active-low write enable.
//   mem_wdata, mem_wdata_oe      ZBT write data and its bus drive enable.
//   mem_rdata                    ZBT read data.
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int ADDR_W  = ZBT_ADDR_W,
    parameter int DATA_W  = ZBT_DATA_W,
    parameter int MEM_LAT = ZBT_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_flag,
    input  logic              vga_flag,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              done_vga,
    output logic [DATA_W-1:0] vga_pixel,
    output logic              vga_pixel_vld,
    input  logic              wr_req,
    input  logic [ADDR_W-2:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we_b,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int ROW_W = ADDR_W - 1;

    logic              display_bank;
    logic              swap_pend;
    logic              swap_now;
    logic              read_bank;
    logic [ROW_W-1:0]  rd_offset;
    op_e               slot;
    logic [DATA_W-1:0] pipe_data_in;
    op_e               tail_op;
    logic [DATA_W-1:0] tail_data;
    logic              rd_due;
    logic              unused_hcount_lsb;

    // Words hold pixel pairs, so the low column bit never reaches the address.
    assign unused_hcount_lsb = hcount[0];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        slot = OP_IDLE;
        if (vga_flag)    slot = OP_RD;
        else if (wr_req) slot = OP_WR;

        // The swap is decided combinationally so the very read that starts
        // the new frame already uses the new display bank.
        swap_now  = vga_flag && swap_pend && (hcount == 10'd0) && (vcount == 10'd0);
        read_bank = display_bank ^ swap_now;

        // Constant multiply by 320 reduces to (v<<8)+(v<<6); out-of-range
        // inputs simply wrap inside the bank.
        rd_offset = ROW_W'(vcount) * ROW_W'(LINE_WORDS) + ROW_W'(hcount[9:1]);

        pipe_data_in = (slot == OP_WR) ? wr_data : '0;
    end

    zbt_op_pipe #(
        .DEPTH  (MEM_LAT),
        .DATA_W (DATA_W)
    ) u_op_pipe (
        .clock    (clock),
        .reset    (reset),
        .op_in    (slot),
        .data_in  (pipe_data_in),
        .op_out   (tail_op),
        .data_out (tail_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            display_bank  <= 1'b0;
            swap_pend     <= 1'b0;
            done_vga      <= 1'b0;
            wr_ack        <= 1'b0;
            mem_addr      <= '0;
            mem_we_b      <= 1'b1;
            mem_wdata     <= '0;
            mem_wdata_oe  <= 1'b0;
            rd_due        <= 1'b0;
            vga_pixel     <= '0;
            vga_pixel_vld <= 1'b0;
        end else begin
            // Issue stage.
            done_vga <= (slot == OP_RD);
            wr_ack   <= (slot == OP_WR);
            mem_we_b <= (slot != OP_WR);
            case (slot)
                OP_RD:   mem_addr <= {read_bank, rd_offset};
                OP_WR:   mem_addr <= {~display_bank, wr_addr};
                default: mem_addr <= mem_addr;
            endcase

            if (swap_now) display_bank <= ~display_bank;
            // A new frame_flag wins over the clear on the swap cycle.
            if (frame_flag)    swap_pend <= 1'b1;
            else if (swap_now) swap_pend <= 1'b0;

            // Data phase of ops issued MEM_LAT cycles ago.
            mem_wdata_oe <= (tail_op == OP_WR);
            if (tail_op == OP_WR) mem_wdata <= tail_data;

            // Read data is on the bus during the cycle after the tail stage,
            // so it is captured one edge later.
            rd_due        <= (tail_op == OP_RD);
            vga_pixel_vld <= rd_due;
            if (rd_due) vga_pixel <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: directed scenarios then random traffic,
// all compared against a slot-level reference model with a simple ZBT data model.
module tb_vga_frame_reader;

    localparam int K_IDLE = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_flag;
    logic        vga_flag;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        done_vga;
    logic [35:0] vga_pixel;
    logic        vga_pixel_vld;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [35:0] wr_data;
    logic        wr_ack;
    logic [18:0] mem_addr;
    logic        mem_we_b;
    logic [35:0] mem_wdata;
    logic        mem_wdata_oe;
    logic [35:0] mem_rdata;

    always #5 clock = ~clock;

    vga_frame_reader dut (
        .clock         (clock),
        .reset         (reset),
        .frame_flag    (frame_flag),
        .vga_flag      (vga_flag),
        .hcount        (hcount),
        .vcount        (vcount),
        .done_vga      (done_vga),
        .vga_pixel     (vga_pixel),
        .vga_pixel_vld (vga_pixel_vld),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .mem_addr      (mem_addr),
        .mem_we_b      (mem_we_b),
        .mem_wdata     (mem_wdata),
        .mem_wdata_oe  (mem_wdata_oe),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        int          kind;
        logic [18:0] addr;
        logic [35:0] data;
    } slot_t;

    int          tests = 0;
    int          fails = 0;
    slot_t       hist[$];      // hist[0] = slot issued this cycle, hist[k] = k cycles ago
    bit          m_bank;
    bit          m_pend;
    logic [35:0] m_pixel;

    // ZBT content model: each address holds a distinct word derived from it.
    function automatic logic [35:0] zbt_word(input logic [18:0] a);
        return {a, ~a[16:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check every output.
    task automatic step(input bit rst, input bit vf, input logic [9:0] h, input logic [9:0] v,
                        input bit wr, input logic [17:0] wa, input logic [35:0] wd, input bit ff);
        slot_t e;
        bit    swap;
        reset      = rst;
        vga_flag   = vf;
        hcount     = h;
        vcount     = v;
        wr_req     = wr;
        wr_addr    = wa;
        wr_data    = wd;
        frame_flag = ff;

        e.kind = K_IDLE;
        e.addr = '0;
        e.data = '0;
        if (rst) begin
            m_bank  = 1'b0;
            m_pend  = 1'b0;
            m_pixel = '0;
            hist.delete();
            for (int i = 0; i < 3; i++) hist.push_front(e);
        end else begin
            swap = vf && m_pend && (h == 0) && (v == 0);
            if (vf) begin
                if (swap) m_bank = !m_bank;
                e.kind = K_RD;
                e.addr = {m_bank, 18'(v * 320 + h / 2)};
            end else if (wr) begin
                e.kind = K_WR;
                e.addr = {!m_bank, wa};
                e.data = wd;
            end
            if (ff)        m_pend = 1'b1;
            else if (swap) m_pend = 1'b0;
        end
        hist.push_front(e);
        if (hist.size() > 4) void'(hist.pop_back());

        @(posedge clock);
        @(negedge clock);

        if (rst) begin
            check("rst_done_vga", 64'(done_vga), 64'd0);
            check("rst_wr_ack", 64'(wr_ack), 64'd0);
            check("rst_mem_addr", 64'(mem_addr), 64'd0);
            check("rst_mem_we_b", 64'(mem_we_b), 64'd1);
            check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
            check("rst_mem_wdata_oe", 64'(mem_wdata_oe), 64'd0);
            check("rst_vga_pixel", 64'(vga_pixel), 64'd0);
            check("rst_vga_pixel_vld", 64'(vga_pixel_vld), 64'd0);
        end else begin
            check("done_vga", 64'(done_vga), 64'(hist[0].kind == K_RD));
            check("wr_ack", 64'(wr_ack), 64'(hist[0].kind == K_WR));
            check("mem_we_b", 64'(mem_we_b), 64'(hist[0].kind != K_WR));
            if (hist[0].kind != K_IDLE) check("mem_addr", 64'(mem_addr), 64'(hist[0].addr));
            check("mem_wdata_oe", 64'(mem_wdata_oe), 64'(hist[2].kind == K_WR));
            if (hist[2].kind == K_WR) check("mem_wdata", 64'(mem_wdata), 64'(hist[2].data));
            check("vga_pixel_vld", 64'(vga_pixel_vld), 64'(hist[3].kind == K_RD));
            if (hist[3].kind == K_RD) m_pixel = zbt_word(hist[3].addr);
            check("vga_pixel", 64'(vga_pixel), 64'(m_pixel));
        end

        // ZBT model: data for the read issued two edges ago is on the bus now;
        // anything else on the bus is junk the reader must ignore.
        if (hist[2].kind == K_RD) mem_rdata = zbt_word(hist[2].addr);
        else                      mem_rdata = 36'({$urandom(), $urandom()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 10'd0, 10'd0, 0, 18'd0, 36'd0, 0);
    endtask

    task automatic rd(input logic [9:0] h, input logic [9:0] v, input bit ff);
        step(0, 1, h, v, 0, 18'd0, 36'd0, ff);
    endtask

    initial begin
        bit          wr_pending;
        logic [17:0] p_addr;
        logic [35:0] p_data;
        bit          vf;
        logic [9:0]  h;
        logic [9:0]  v;

        mem_rdata = '0;
        step(1, 0, 10'd0, 10'd0, 0, 18'd0, 36'd0, 0);
        step(1, 0, 10'd0, 10'd0, 0, 18'd0, 36'd0, 0);

        // Read at (4,2) on bank 0; data returns three cycles after the address.
        rd(10'd4, 10'd2, 0);
        check("rd_h4v2_addr", 64'(mem_addr), 64'h00282);
        check("rd_h4v2_done", 64'(done_vga), 64'd1);
        idle(3);
        check("rd_h4v2_vld", 64'(vga_pixel_vld), 64'd1);
        check("rd_h4v2_pixel", 64'(vga_pixel), 64'(zbt_word(19'h00282)));

        // Write into the back bank; data phase exactly two cycles later.
        step(0, 0, 10'd0, 10'd0, 1, 18'h00010, 36'h123456789, 0);
        check("wr_addr_bank1", 64'(mem_addr), 64'h40010);
        check("wr_we_b", 64'(mem_we_b), 64'd0);
        check("wr_ack_pulse", 64'(wr_ack), 64'd1);
        idle(2);
        check("wr_data_phase", 64'(mem_wdata), 64'h123456789);
        check("wr_oe_phase", 64'(mem_wdata_oe), 64'd1);
        idle(1);
        check("wr_oe_one_cycle", 64'(mem_wdata_oe), 64'd0);

        // Read priority: write starves for three cycles, then issues.
        for (int i = 0; i < 3; i++)
            step(0, 1, 10'(2 * i), 10'd7, 1, 18'h00abc, 36'h0fedcba98, 0);
        step(0, 0, 10'd0, 10'd0, 1, 18'h00abc, 36'h0fedcba98, 0);
        check("starved_wr_addr", 64'(mem_addr), 64'h40abc);
        idle(3);

        // Bank swap at (0,0) after frame_flag; writes then go to bank 0.
        step(0, 0, 10'd0, 10'd0, 0, 18'd0, 36'd0, 1);
        rd(10'd0, 10'd0, 0);
        check("swap_read_bank1", 64'(mem_addr), 64'h40000);
        step(0, 0, 10'd0, 10'd0, 1, 18'h00020, 36'h000000055, 0);
        check("swap_write_bank0", 64'(mem_addr), 64'h00020);
        rd(10'd0, 10'd0, 0);
        check("no_swap_stays_bank1", 64'(mem_addr), 64'h40000);
        // frame_flag on the swap cycle keeps the swap pending for the next frame.
        step(0, 0, 10'd0, 10'd0, 0, 18'd0, 36'd0, 1);
        rd(10'd0, 10'd0, 1);
        check("swap_back_bank0", 64'(mem_addr), 64'h00000);
        rd(10'd0, 10'd0, 0);
        check("pending_swap_bank1", 64'(mem_addr), 64'h40000);
        idle(3);

        // Ops in flight are flushed by reset.
        rd(10'd10, 10'd1, 0);
        step(0, 0, 10'd0, 10'd0, 1, 18'h00033, 36'h9aaaaaaaa, 0);
        rd(10'd12, 10'd1, 0);
        step(1, 0, 10'd0, 10'd0, 0, 18'd0, 36'd0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("flush_no_vld", 64'(vga_pixel_vld), 64'd0);
            check("flush_no_oe", 64'(mem_wdata_oe), 64'd0);
        end

        // Random traffic against the model.
        wr_pending = 0;
        p_addr     = '0;
        p_data     = '0;
        for (int n = 0; n < 400; n++) begin
            if (!wr_pending && $urandom_range(0, 2) == 0) begin
                wr_pending = 1;
                p_addr     = 18'($urandom());
                p_data     = 36'({$urandom(), $urandom()});
            end
            vf = ($urandom_range(0, 1) == 1);
            h  = 10'($urandom_range(0, 319) * 2);
            v  = 10'($urandom_range(0, 479));
            if ($urandom_range(0, 7) == 0) begin
                h = 10'd0;
                v = 10'd0;
            end
            step(($urandom_range(0, 99) == 0), vf, h, v, wr_pending, p_addr, p_data,
                 ($urandom_range(0, 9) == 0));
            if (hist[0].kind == K_WR) wr_pending = 0;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
